// File: rtl/bytecode_decode_pkg.sv
// Shared types and the opcode length table for the bytecode decoder.
package bytecode_pkg;

    // Width of the out_len field (records are 1..5 bytes long).
    localparam int LEN_W = 3;

    typedef enum logic {
        OPCODE,
        OPERAND
    } state_t;

    // Operand count for one opcode; count is 0 whenever illegal is set.
    typedef struct packed {
        logic       illegal;
        logic [2:0] count;
    } op_info_t;

    // Pure lookup of the operand-byte count; the 4-operand opcodes only
    // exist when the decoder is built for 4 operand bytes.
    function automatic op_info_t op_len(input logic [7:0] opcode, input int max_operands);
        op_info_t info;
        info.illegal = 1'b0;
        info.count   = 3'd0;
        case (opcode) inside
            8'h10, 8'h12, [8'h15:8'h19], [8'h36:8'h3A], 8'hA9, 8'hBC:
                info.count = 3'd1;
            8'h11, 8'h13, 8'h14, 8'h84, [8'h99:8'hA8], [8'hB2:8'hB8],
            8'hBB, 8'hBD, 8'hC0, 8'hC1, 8'hC6, 8'hC7:
                info.count = 3'd2;
            8'hC8, 8'hC9:
                if (max_operands >= 4) info.count   = 3'd4;
                else                   info.illegal = 1'b1;
            8'hAA, 8'hAB, 8'hB9, 8'hBA, 8'hC4, 8'hC5, [8'hCA:8'hFF]:
                info.illegal = 1'b1;
            default: ;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/bytecode_decode_if.sv
// Byte-stream input, flush/redirect and decoded-record output of the decoder.
interface bytecode_decode_if
    import bytecode_pkg::*;
#(
    parameter int PC_W         = 16,
    parameter int MAX_OPERANDS = 2
);
    localparam int OPND_W = 8 * MAX_OPERANDS;

    logic [7:0]        in_byte;
    logic              in_valid;
    logic              in_ready;
    logic              flush;
    logic [PC_W-1:0]   flush_pc;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_opcode;
    logic [OPND_W-1:0] out_operand;
    logic [LEN_W-1:0]  out_len;
    logic [PC_W-1:0]   out_pc;
    logic              out_illegal;
    logic              busy;

    // Fetch/execute side: supplies bytes and redirects, consumes records.
    modport master (
        output in_byte, in_valid, flush, flush_pc, out_ready,
        input  in_ready, out_valid, out_opcode, out_operand, out_len,
               out_pc, out_illegal, busy
    );

    // Decoder side.
    modport slave (
        input  in_byte, in_valid, flush, flush_pc, out_ready,
        output in_ready, out_valid, out_opcode, out_operand, out_len,
               out_pc, out_illegal, busy
    );

endinterface

// File: rtl/bytecode_decode.sv
// Streaming JVM bytecode decoder: assembles opcode + operand bytes into one
// record tagged with the PC of its opcode byte.
module bytecode_decode
    import bytecode_pkg::*;
#(
    parameter int PC_W         = 16,
    parameter int MAX_OPERANDS = 2
) (
    input logic               clk,
    input logic               rst,
    bytecode_decode_if.slave  bus
);

    localparam int OPND_W = 8 * MAX_OPERANDS;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_rem;
    logic [PC_W-1:0]   r_pc;
    logic [7:0]        r_op;
    logic [PC_W-1:0]   r_op_pc;
    logic [2:0]        r_op_cnt;
    logic [OPND_W-9:0] r_acc;

    logic              r_out_valid;
    logic [7:0]        r_out_opcode;
    logic [OPND_W-1:0] r_out_operand;
    logic [LEN_W-1:0]  r_out_len;
    logic [PC_W-1:0]   r_out_pc;
    logic              r_out_illegal;

    op_info_t          w_info;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_emit;
    logic [OPND_W-1:0] w_acc_nxt;
    logic [7:0]        w_rec_op;
    logic [PC_W-1:0]   w_rec_pc;
    logic [LEN_W-1:0]  w_rec_len;
    logic              w_rec_ill;

    assign w_info = op_len(bus.in_byte, MAX_OPERANDS);

    // State register; reset drops any partial instruction without a clock.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) r_state <= OPCODE;
        else     r_state <= w_state_nxt;
    end

    // Next state: flush wins, otherwise advance only on an accepted byte.
    always_comb begin
        // NOTE: default first, so no path leaves the signal unassigned (no latch).
        w_state_nxt = r_state;
        if (bus.flush) begin
            w_state_nxt = OPCODE;
        end else if (w_accept) begin
            case (r_state)
                OPCODE:  if (!w_info.illegal && w_info.count != 3'd0) w_state_nxt = OPERAND;
                OPERAND: if (r_rem == 3'd1) w_state_nxt = OPCODE;
                default: w_state_nxt = OPCODE;
            endcase
        end
    end

    // Handshake, emit strobe and the record fields to load on emit.
    always_comb begin
        w_in_ready = !rst && !bus.flush && (!r_out_valid || bus.out_ready);
        w_accept   = bus.in_valid && w_in_ready;
        w_emit     = 1'b0;
        w_acc_nxt  = '0;
        w_rec_op   = r_op;
        w_rec_pc   = r_op_pc;
        w_rec_len  = LEN_W'(1) + r_op_cnt;
        w_rec_ill  = 1'b0;
        if (r_state == OPCODE) begin
            w_emit    = w_accept && (w_info.illegal || w_info.count == 3'd0);
            w_rec_op  = bus.in_byte;
            w_rec_pc  = r_pc;
            w_rec_len = LEN_W'(1) + w_info.count;
            w_rec_ill = w_info.illegal;
        end else begin
            w_emit    = w_accept && (r_rem == 3'd1);
            w_acc_nxt = {r_acc, bus.in_byte};
        end
    end

    // Datapath: PC, operand accumulator and the output record slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem         <= 3'd0;
            r_pc          <= '0;
            r_op          <= 8'd0;
            r_op_pc       <= '0;
            r_op_cnt      <= 3'd0;
            r_acc         <= '0;
            r_out_valid   <= 1'b0;
            r_out_opcode  <= 8'd0;
            r_out_operand <= '0;
            r_out_len     <= '0;
            r_out_pc      <= '0;
            r_out_illegal <= 1'b0;
        end else if (bus.flush) begin
            r_rem       <= 3'd0;
            r_pc        <= bus.flush_pc;
            r_out_valid <= 1'b0;
        end else begin
            if (r_out_valid && bus.out_ready) r_out_valid <= 1'b0;
            if (w_accept) begin
                r_pc  <= r_pc + PC_W'(1);
                r_acc <= w_acc_nxt[OPND_W-9:0];
                if (r_state == OPCODE) begin
                    r_op     <= bus.in_byte;
                    r_op_pc  <= r_pc;
                    r_op_cnt <= w_info.count;
                    r_rem    <= w_info.count;
                end else begin
                    r_rem <= r_rem - 3'd1;
                end
            end
            if (w_emit) begin
                r_out_valid   <= 1'b1;
                r_out_opcode  <= w_rec_op;
                r_out_operand <= w_acc_nxt;
                r_out_len     <= w_rec_len;
                r_out_pc      <= w_rec_pc;
                r_out_illegal <= w_rec_ill;
            end
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_opcode  = r_out_opcode;
    assign bus.out_operand = r_out_operand;
    assign bus.out_len     = r_out_len;
    assign bus.out_pc      = r_out_pc;
    assign bus.out_illegal = r_out_illegal;
    assign bus.busy        = (r_state == OPERAND);

endmodule

// File: tb/tb_bytecode_decode.sv
// Bench for bytecode_decode: a 16-bit-PC / 2-operand instance and a
// 4-bit-PC / 4-operand instance share one stimulus stream; each is compared
// with its own instruction-level reference model, plus directed tables.
module tb_bytecode_decode;

    logic clk;
    logic rst;

    bytecode_decode_if #(.PC_W(16), .MAX_OPERANDS(2)) bus_a ();
    bytecode_decode_if #(.PC_W(4),  .MAX_OPERANDS(4)) bus_b ();

    bytecode_decode #(.PC_W(16), .MAX_OPERANDS(2)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    bytecode_decode #(.PC_W(4),  .MAX_OPERANDS(4)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Operand bytes per opcode, -1 for unsupported opcodes.
    function automatic int ref_oplen(input logic [7:0] op, input int maxo);
        if (op inside {8'hC8, 8'hC9}) return (maxo == 4) ? 4 : -1;
        if (op inside {8'hAA, 8'hAB, 8'hB9, 8'hBA, 8'hC4, 8'hC5} || op >= 8'hCA) return -1;
        if (op inside {8'h10, 8'h12, [8'h15:8'h19], [8'h36:8'h3A], 8'hA9, 8'hBC}) return 1;
        if (op inside {8'h11, 8'h13, 8'h14, 8'h84, [8'h99:8'hA8], [8'hB2:8'hB8],
                       8'hBB, 8'hBD, 8'hC0, 8'hC1, 8'hC6, 8'hC7}) return 2;
        return 0;
    endfunction

    // Instruction-level view: bytes gathered so far plus the pending record.
    typedef struct packed {
        logic [15:0] pc;
        logic [2:0]  held;
        logic [7:0]  op;
        logic [15:0] op_pc;
        logic [31:0] acc;
        logic        ov;
        logic [7:0]  o_op;
        logic [31:0] o_opnd;
        logic [2:0]  o_len;
        logic [15:0] o_pc;
        logic        o_ill;
    } mdl_t;

    mdl_t ma;
    mdl_t mb;

    function automatic logic mdl_ready(input mdl_t s, input logic fl, input logic ordy);
        return !fl && (!s.ov || ordy);
    endfunction

    function automatic mdl_t mdl_step(input mdl_t s, input int pcw, input int maxo,
                                      input logic fl, input logic [15:0] fpc,
                                      input logic iv, input logic [7:0] ib, input logic ordy);
        mdl_t n;
        int   len;
        int   mask;
        n    = s;
        mask = (1 << pcw) - 1;
        if (fl) begin
            n.ov   = 1'b0;
            n.held = 3'd0;
            n.pc   = 16'(int'(fpc) & mask);
            return n;
        end
        if (s.ov && ordy) n.ov = 1'b0;
        if (iv && mdl_ready(s, fl, ordy)) begin
            if (s.held == 3'd0) begin
                n.op    = ib;
                n.op_pc = s.pc;
                n.acc   = 32'd0;
            end else begin
                n.acc = {s.acc[23:0], ib};
            end
            n.held = s.held + 3'd1;
            n.pc   = 16'((int'(s.pc) + 1) & mask);
            len    = ref_oplen(n.op, maxo);
            if (len < 0 || int'(n.held) == len + 1) begin
                n.ov     = 1'b1;
                n.o_op   = n.op;
                n.o_opnd = (len < 0) ? 32'd0 : n.acc;
                n.o_len  = (len < 0) ? 3'd1 : 3'(len + 1);
                n.o_pc   = n.op_pc;
                n.o_ill  = (len < 0);
                n.held   = 3'd0;
            end
        end
        return n;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic fl, input logic [15:0] fpc, input logic iv,
                         input logic [7:0] ib, input logic ordy);
        bus_a.flush     = fl;
        bus_a.flush_pc  = fpc;
        bus_a.in_valid  = iv;
        bus_a.in_byte   = ib;
        bus_a.out_ready = ordy;
        bus_b.flush     = fl;
        bus_b.flush_pc  = fpc[3:0];
        bus_b.in_valid  = iv;
        bus_b.in_byte   = ib;
        bus_b.out_ready = ordy;
    endtask

    task automatic cmp_outputs();
        check("a_out_valid", 64'(bus_a.out_valid), 64'(ma.ov));
        check("a_busy", 64'(bus_a.busy), 64'(ma.held != 3'd0));
        if (ma.ov) begin
            check("a_opcode",  64'(bus_a.out_opcode),  64'(ma.o_op));
            check("a_operand", 64'(bus_a.out_operand), 64'(ma.o_opnd));
            check("a_len",     64'(bus_a.out_len),     64'(ma.o_len));
            check("a_pc",      64'(bus_a.out_pc),      64'(ma.o_pc));
            check("a_illegal", 64'(bus_a.out_illegal), 64'(ma.o_ill));
        end
        check("b_out_valid", 64'(bus_b.out_valid), 64'(mb.ov));
        check("b_busy", 64'(bus_b.busy), 64'(mb.held != 3'd0));
        if (mb.ov) begin
            check("b_opcode",  64'(bus_b.out_opcode),  64'(mb.o_op));
            check("b_operand", 64'(bus_b.out_operand), 64'(mb.o_opnd));
            check("b_len",     64'(bus_b.out_len),     64'(mb.o_len));
            check("b_pc",      64'(bus_b.out_pc),      64'(mb.o_pc));
            check("b_illegal", 64'(bus_b.out_illegal), 64'(mb.o_ill));
        end
    endtask

    // One clock: drive at the falling edge, check ready before the rising
    // edge, advance the models on it, check outputs at the next falling edge.
    task automatic cycle(input logic fl, input logic [15:0] fpc, input logic iv,
                         input logic [7:0] ib, input logic ordy, output logic rdy_a);
        drive(fl, fpc, iv, ib, ordy);
        #1;
        rdy_a = bus_a.in_ready;
        check("a_in_ready", 64'(bus_a.in_ready), 64'(mdl_ready(ma, fl, ordy)));
        check("b_in_ready", 64'(bus_b.in_ready), 64'(mdl_ready(mb, fl, ordy)));
        @(posedge clk);
        ma = mdl_step(ma, 16, 2, fl, fpc, iv, ib, ordy);
        mb = mdl_step(mb, 4, 4, fl, fpc, iv, ib, ordy);
        @(negedge clk);
        cmp_outputs();
    endtask

    task automatic send(input logic [7:0] ib);
        logic r;
        cycle(1'b0, 16'h0, 1'b1, ib, 1'b1, r);
    endtask

    task automatic flush_to(input logic [15:0] fpc);
        logic r;
        cycle(1'b1, fpc, 1'b0, 8'h00, 1'b1, r);
    endtask

    // ---------------- directed vector table (instance A) ----------------
    typedef struct packed {
        logic        fl;
        logic [15:0] fpc;
        logic        iv;
        logic [7:0]  ib;
        logic        ordy;
        logic        e_rdy;
        logic        e_ov;
        logic [7:0]  e_op;
        logic [15:0] e_opnd;
        logic [2:0]  e_len;
        logic [15:0] e_pc;
        logic        e_ill;
        logic        e_busy;
    } vec_t;

    function automatic vec_t mkv(input int fl, input int fpc, input int iv, input int ib,
                                 input int ordy, input int rdy, input int ov, input int op,
                                 input int opnd, input int len, input int pc, input int ill,
                                 input int busy);
        vec_t v;
        v.fl = fl[0];       v.fpc = 16'(fpc);   v.iv = iv[0];
        v.ib = 8'(ib);      v.ordy = ordy[0];   v.e_rdy = rdy[0];
        v.e_ov = ov[0];     v.e_op = 8'(op);    v.e_opnd = 16'(opnd);
        v.e_len = 3'(len);  v.e_pc = 16'(pc);   v.e_ill = ill[0];
        v.e_busy = busy[0];
        return v;
    endfunction

    vec_t vecs[16];

    initial begin
        logic r;

        //            fl fpc    iv ib    ordy rdy ov op     opnd    len pc     ill busy
        vecs[0]  = mkv(0, 0,     1, 'h10, 1,   1,  0, 0,     0,      0,  0,     0,  1);
        vecs[1]  = mkv(0, 0,     1, 'h05, 1,   1,  1, 'h10,  'h0005, 2,  0,     0,  0);
        vecs[2]  = mkv(0, 0,     1, 'h60, 1,   1,  1, 'h60,  0,      1,  2,     0,  0);
        vecs[3]  = mkv(0, 0,     1, 'hA7, 1,   1,  0, 0,     0,      0,  0,     0,  1);
        vecs[4]  = mkv(0, 0,     1, 'hFF, 1,   1,  0, 0,     0,      0,  0,     0,  1);
        vecs[5]  = mkv(0, 0,     1, 'hFE, 1,   1,  1, 'hA7,  'hFFFE, 3,  3,     0,  0);
        vecs[6]  = mkv(0, 0,     1, 'h04, 1,   1,  1, 'h04,  0,      1,  6,     0,  0);
        vecs[7]  = mkv(0, 0,     1, 'h05, 0,   0,  1, 'h04,  0,      1,  6,     0,  0);
        vecs[8]  = mkv(0, 0,     1, 'h05, 0,   0,  1, 'h04,  0,      1,  6,     0,  0);
        vecs[9]  = mkv(0, 0,     1, 'h05, 1,   1,  1, 'h05,  0,      1,  7,     0,  0);
        vecs[10] = mkv(0, 0,     1, 'h11, 1,   1,  0, 0,     0,      0,  0,     0,  1);
        vecs[11] = mkv(0, 0,     1, 'h12, 1,   1,  0, 0,     0,      0,  0,     0,  1);
        vecs[12] = mkv(1, 'h100, 1, 'h99, 1,   0,  0, 0,     0,      0,  0,     0,  0);
        vecs[13] = mkv(0, 0,     1, 'h03, 1,   1,  1, 'h03,  0,      1,  'h100, 0,  0);
        vecs[14] = mkv(0, 0,     1, 'hC8, 1,   1,  1, 'hC8,  0,      1,  'h101, 1,  0);
        vecs[15] = mkv(0, 0,     0, 'h00, 1,   1,  0, 0,     0,      0,  0,     0,  0);

        // Reset state, with in_ready held low while reset is asserted.
        rst = 1'b1;
        drive(1'b0, 16'h0, 1'b1, 8'h00, 1'b1);
        #1;
        check("rst_a_in_ready", 64'(bus_a.in_ready), 64'd0);
        check("rst_b_in_ready", 64'(bus_b.in_ready), 64'd0);
        @(negedge clk);
        check("rst_a_out_valid", 64'(bus_a.out_valid),   64'd0);
        check("rst_a_opcode",    64'(bus_a.out_opcode),  64'd0);
        check("rst_a_operand",   64'(bus_a.out_operand), 64'd0);
        check("rst_a_len",       64'(bus_a.out_len),     64'd0);
        check("rst_a_pc",        64'(bus_a.out_pc),      64'd0);
        check("rst_a_illegal",   64'(bus_a.out_illegal), 64'd0);
        check("rst_a_busy",      64'(bus_a.busy),        64'd0);
        check("rst_b_out_valid", 64'(bus_b.out_valid),   64'd0);
        check("rst_b_busy",      64'(bus_b.busy),        64'd0);
        rst = 1'b0;
        ma = '0;
        mb = '0;

        // Directed table on instance A; both instances also track their models.
        for (int i = 0; i < 16; i++) begin
            cycle(vecs[i].fl, vecs[i].fpc, vecs[i].iv, vecs[i].ib, vecs[i].ordy, r);
            check($sformatf("vec%0d_in_ready", i), 64'(r), 64'(vecs[i].e_rdy));
            check($sformatf("vec%0d_out_valid", i), 64'(bus_a.out_valid), 64'(vecs[i].e_ov));
            check($sformatf("vec%0d_busy", i), 64'(bus_a.busy), 64'(vecs[i].e_busy));
            if (vecs[i].e_ov) begin
                check($sformatf("vec%0d_opcode", i),  64'(bus_a.out_opcode),  64'(vecs[i].e_op));
                check($sformatf("vec%0d_operand", i), 64'(bus_a.out_operand), 64'(vecs[i].e_opnd));
                check($sformatf("vec%0d_len", i),     64'(bus_a.out_len),     64'(vecs[i].e_len));
                check($sformatf("vec%0d_pc", i),      64'(bus_a.out_pc),      64'(vecs[i].e_pc));
                check($sformatf("vec%0d_illegal", i), 64'(bus_a.out_illegal), 64'(vecs[i].e_ill));
            end
        end

        // goto_w on the 4-operand instance.
        flush_to(16'h0000);
        send(8'hC8);
        check("gw_b_busy", 64'(bus_b.busy), 64'd1);
        send(8'h00);
        send(8'h00);
        send(8'h01);
        send(8'h00);
        check("gw_b_out_valid", 64'(bus_b.out_valid),   64'd1);
        check("gw_b_operand",   64'(bus_b.out_operand), 64'h0000_0100);
        check("gw_b_len",       64'(bus_b.out_len),     64'd5);
        check("gw_b_pc",        64'(bus_b.out_pc),      64'd0);
        check("gw_b_illegal",   64'(bus_b.out_illegal), 64'd0);

        // PC wrap on the 4-bit PC instance.
        flush_to(16'h000F);
        send(8'h00);
        check("wrap_b_pc0", 64'(bus_b.out_pc), 64'hF);
        send(8'h00);
        check("wrap_b_pc1", 64'(bus_b.out_pc), 64'h0);
        check("wrap_a_pc1", 64'(bus_a.out_pc), 64'h10);

        // Reset in the middle of an instruction acts without a clock edge.
        send(8'h11);
        check("mid_a_busy_before", 64'(bus_a.busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_a_busy",      64'(bus_a.busy),      64'd0);
        check("mid_b_busy",      64'(bus_b.busy),      64'd0);
        check("mid_a_out_valid", 64'(bus_a.out_valid), 64'd0);
        check("mid_a_in_ready",  64'(bus_a.in_ready),  64'd0);
        @(negedge clk);
        rst = 1'b0;
        ma = '0;
        mb = '0;

        // Randomized traffic against the models.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 19) == 0), 16'($urandom),
                  ($urandom_range(0, 9) < 8), 8'($urandom),
                  ($urandom_range(0, 9) < 7), r);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
